// File: rtl/exu_alu_wbck_buf.sv
// rtl/exu_alu_wbck_buf.sv - ALU result write-back buffer (circular FIFO with optional bypass)
// Optional same-cycle bypass when empty: define E203_WBCK_BUF_BYPASS_EN.
module exu_alu_wbck_buf #(
  parameter int DW    = 32,
  parameter int RDW   = 5,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       alu_o_valid,
  output logic                       alu_o_ready,
  input  logic [DW-1:0]              alu_o_wbck_wdat,
  input  logic [RDW-1:0]             alu_o_rdidx,
  input  logic                       alu_o_rdwen,
  input  logic                       alu_o_wbck_err,
  input  logic                       alu_o_cmt_ecall,
  input  logic                       alu_o_cmt_ebreak,
  input  logic                       alu_o_cmt_wfi,
  output logic                       wbck_o_valid,
  input  logic                       wbck_o_ready,
  output logic [DW-1:0]              wbck_o_wdat,
  output logic [RDW-1:0]             wbck_o_rdidx,
  output logic                       wbck_o_rf_wen,
  output logic                       wbck_o_err,
  output logic                       wbck_o_ecall,
  output logic                       wbck_o_ebreak,
  output logic                       wbck_o_wfi,
  output logic [$clog2(DEPTH):0]     buf_cnt
);

  localparam int AW  = $clog2(DEPTH);
  localparam int PW  = AW + 1;
  localparam int PLW = DW + RDW + 5;

  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [PLW-1:0] mem [DEPTH];

  logic           full;
  logic           empty;
  logic           bypass;
  logic           push;
  logic           wr_en;
  logic           pop;
  logic [PLW-1:0] in_payload;
  logic [PLW-1:0] head_payload;

  logic [DW-1:0]  head_wdat;
  logic [RDW-1:0] head_rdidx;
  logic           head_rdwen;
  logic           head_err;
  logic           head_ecall;
  logic           head_ebreak;
  logic           head_wfi;

  assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) & (wr_ptr[AW] != rd_ptr[AW]);
  assign empty = (wr_ptr == rd_ptr);

`ifdef E203_WBCK_BUF_BYPASS_EN
  assign bypass = empty & wbck_o_ready;
`else
  assign bypass = 1'b0;
`endif

  // Ready depends only on the pointers, which is the whole point of this stage.
  assign alu_o_ready = ~full;
  assign push        = alu_o_valid & alu_o_ready;
  assign wr_en       = push & ~bypass;
  assign pop         = ~empty & wbck_o_ready;

  assign in_payload = {alu_o_wbck_wdat, alu_o_rdidx, alu_o_rdwen, alu_o_wbck_err,
                       alu_o_cmt_ecall, alu_o_cmt_ebreak, alu_o_cmt_wfi};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Payload storage is intentionally left unreset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= in_payload;
  end

  assign head_payload = bypass ? in_payload : mem[rd_ptr[AW-1:0]];

  assign {head_wdat, head_rdidx, head_rdwen, head_err,
          head_ecall, head_ebreak, head_wfi} = head_payload;

  assign wbck_o_valid  = bypass ? alu_o_valid : ~empty;
  assign wbck_o_wdat   = head_wdat;
  assign wbck_o_rdidx  = head_rdidx;
  assign wbck_o_err    = head_err;
  assign wbck_o_ecall  = head_ecall;
  assign wbck_o_ebreak = head_ebreak;
  assign wbck_o_wfi    = head_wfi;

  // Errors and x0 targets still pop to carry commit flags, but never write the regfile.
  assign wbck_o_rf_wen = wbck_o_valid & head_rdwen & ~head_err & (head_rdidx != '0);

  assign buf_cnt = wr_ptr - rd_ptr;

endmodule

// File: tb/tb_exu_alu_wbck_buf.sv
// tb/tb_exu_alu_wbck_buf.sv - directed self-checking bench for exu_alu_wbck_buf
module tb_exu_alu_wbck_buf;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alu_o_valid = 1'b0;
  logic        alu_o_ready;
  logic [31:0] alu_o_wbck_wdat = '0;
  logic [4:0]  alu_o_rdidx = '0;
  logic        alu_o_rdwen = 1'b0;
  logic        alu_o_wbck_err = 1'b0;
  logic        alu_o_cmt_ecall = 1'b0;
  logic        alu_o_cmt_ebreak = 1'b0;
  logic        alu_o_cmt_wfi = 1'b0;
  logic        wbck_o_valid;
  logic        wbck_o_ready = 1'b0;
  logic [31:0] wbck_o_wdat;
  logic [4:0]  wbck_o_rdidx;
  logic        wbck_o_rf_wen;
  logic        wbck_o_err;
  logic        wbck_o_ecall;
  logic        wbck_o_ebreak;
  logic        wbck_o_wfi;
  logic [1:0]  buf_cnt;

  int checks = 0;
  int errors = 0;

  exu_alu_wbck_buf #(.DW(32), .RDW(5), .DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .alu_o_valid(alu_o_valid), .alu_o_ready(alu_o_ready),
    .alu_o_wbck_wdat(alu_o_wbck_wdat), .alu_o_rdidx(alu_o_rdidx),
    .alu_o_rdwen(alu_o_rdwen), .alu_o_wbck_err(alu_o_wbck_err),
    .alu_o_cmt_ecall(alu_o_cmt_ecall), .alu_o_cmt_ebreak(alu_o_cmt_ebreak),
    .alu_o_cmt_wfi(alu_o_cmt_wfi),
    .wbck_o_valid(wbck_o_valid), .wbck_o_ready(wbck_o_ready),
    .wbck_o_wdat(wbck_o_wdat), .wbck_o_rdidx(wbck_o_rdidx),
    .wbck_o_rf_wen(wbck_o_rf_wen), .wbck_o_err(wbck_o_err),
    .wbck_o_ecall(wbck_o_ecall), .wbck_o_ebreak(wbck_o_ebreak),
    .wbck_o_wfi(wbck_o_wfi), .buf_cnt(buf_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not end, got running, required finished");
    $fatal(1, "timeout");
  end

  typedef struct {
    logic [31:0] wdat;
    logic [4:0]  rdidx;
    logic        rdwen;
    logic        err;
    logic        ecall;
    logic        ebreak;
    logic        wfi;
    logic        exp_rf_wen;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Advance one cycle and land 1ns past the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic [4:0] idx,
                       input logic we, input logic er, input logic ec,
                       input logic eb, input logic wf);
    alu_o_valid      = v;
    alu_o_wbck_wdat  = d;
    alu_o_rdidx      = idx;
    alu_o_rdwen      = we;
    alu_o_wbck_err   = er;
    alu_o_cmt_ecall  = ec;
    alu_o_cmt_ebreak = eb;
    alu_o_cmt_wfi    = wf;
  endtask

  logic [31:0] exp_out;

  initial begin
    vecs[0] = '{32'h1234_5678, 5'd5,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{32'h0000_DEAD, 5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{32'h0000_0003, 5'd3,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{32'h5555_AAAA, 5'd7,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{32'hFFFF_0001, 5'd31, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[5] = '{32'h0BAD_F00D, 5'd1,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    tick();
    check("reset_valid", 32'(wbck_o_valid), 32'd0);
    check("reset_ready", 32'(alu_o_ready), 32'd1);
    check("reset_cnt",   32'(buf_cnt), 32'd0);
    tick();
    rst = 1'b0;

    // Table: push with consumer stalled, then pop and check every head field.
    for (int i = 0; i < 6; i++) begin
      wbck_o_ready = 1'b0;
      drive(1'b1, vecs[i].wdat, vecs[i].rdidx, vecs[i].rdwen, vecs[i].err,
            vecs[i].ecall, vecs[i].ebreak, vecs[i].wfi);
      check($sformatf("v%0d_not_yet_valid", i), 32'(wbck_o_valid), 32'd0);
      tick();
      drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      wbck_o_ready = 1'b1;
      #1;
      check($sformatf("v%0d_valid", i),  32'(wbck_o_valid), 32'd1);
      check($sformatf("v%0d_wdat", i),   wbck_o_wdat, vecs[i].wdat);
      check($sformatf("v%0d_rdidx", i),  32'(wbck_o_rdidx), 32'(vecs[i].rdidx));
      check($sformatf("v%0d_rf_wen", i), 32'(wbck_o_rf_wen), 32'(vecs[i].exp_rf_wen));
      check($sformatf("v%0d_err", i),    32'(wbck_o_err), 32'(vecs[i].err));
      check($sformatf("v%0d_ecall", i),  32'(wbck_o_ecall), 32'(vecs[i].ecall));
      check($sformatf("v%0d_ebreak", i), 32'(wbck_o_ebreak), 32'(vecs[i].ebreak));
      check($sformatf("v%0d_wfi", i),    32'(wbck_o_wfi), 32'(vecs[i].wfi));
      check($sformatf("v%0d_cnt1", i),   32'(buf_cnt), 32'd1);
      tick();
      check($sformatf("v%0d_cnt0", i),   32'(buf_cnt), 32'd0);
      check($sformatf("v%0d_empty", i),  32'(wbck_o_valid), 32'd0);
    end

    // Fill and backpressure.
    wbck_o_ready = 1'b0;
    drive(1'b1, 32'hA, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'hB, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("fill_ready_one", 32'(alu_o_ready), 32'd1);
    tick();
    check("fill_cnt2",   32'(buf_cnt), 32'd2);
    check("fill_ready0", 32'(alu_o_ready), 32'd0);
    drive(1'b1, 32'hC, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    check("fill_third_rejected", 32'(buf_cnt), 32'd2);
    check("fill_head_a", wbck_o_wdat, 32'hA);
    drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    wbck_o_ready = 1'b1;
    #1;
    check("drain_ready_still0", 32'(alu_o_ready), 32'd0);
    tick();
    check("drain_ready1", 32'(alu_o_ready), 32'd1);
    check("drain_head_b", wbck_o_wdat, 32'hB);
    check("drain_cnt1",   32'(buf_cnt), 32'd1);
    tick();
    check("drain_cnt0",   32'(buf_cnt), 32'd0);
    check("drain_empty",  32'(wbck_o_valid), 32'd0);

    // Streaming: push and pop every cycle, pointers wrap several times.
    wbck_o_ready = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      if (k <= 9) drive(1'b1, 32'(k), 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      else        drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      #1;
`ifdef E203_WBCK_BUF_BYPASS_EN
      exp_out = 32'(k);
      if (k <= 9) begin
        check($sformatf("stream_valid_%0d", k), 32'(wbck_o_valid), 32'd1);
        check($sformatf("stream_out_%0d", k), wbck_o_wdat, exp_out);
      end
      check($sformatf("stream_cnt_%0d", k), 32'(buf_cnt), 32'd0);
`else
      exp_out = 32'(k - 1);
      if (k >= 2) begin
        check($sformatf("stream_valid_%0d", k), 32'(wbck_o_valid), 32'd1);
        check($sformatf("stream_out_%0d", k), wbck_o_wdat, exp_out);
      end
      check($sformatf("stream_cnt_%0d", k), 32'(buf_cnt), (k >= 2) ? 32'd1 : 32'd0);
`endif
      tick();
    end
    check("stream_end_empty", 32'(wbck_o_valid), 32'd0);
    check("stream_end_cnt",   32'(buf_cnt), 32'd0);

    // Asynchronous reset with two entries held.
    wbck_o_ready = 1'b0;
    drive(1'b1, 32'h11, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 32'h22, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("prerst_cnt2", 32'(buf_cnt), 32'd2);
    #2;
    rst = 1'b1;
    #1;
    check("rst_valid", 32'(wbck_o_valid), 32'd0);
    check("rst_cnt",   32'(buf_cnt), 32'd0);
    check("rst_ready", 32'(alu_o_ready), 32'd1);
    tick();
    rst = 1'b0;
    drive(1'b1, 32'h77, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    wbck_o_ready = 1'b1;
    #1;
    check("postrst_valid", 32'(wbck_o_valid), 32'd1);
    check("postrst_first", wbck_o_wdat, 32'h77);
    check("postrst_cnt",   32'(buf_cnt), 32'd1);
    tick();
    check("postrst_drained", 32'(buf_cnt), 32'd0);

`ifdef E203_WBCK_BUF_BYPASS_EN
    wbck_o_ready = 1'b1;
    drive(1'b1, 32'hCAFE, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    check("byp_valid",  32'(wbck_o_valid), 32'd1);
    check("byp_wdat",   wbck_o_wdat, 32'hCAFE);
    check("byp_rf_wen", 32'(wbck_o_rf_wen), 32'd1);
    check("byp_cnt",    32'(buf_cnt), 32'd0);
    tick();
    drive(1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    check("byp_not_stored", 32'(buf_cnt), 32'd0);
    check("byp_after_idle", 32'(wbck_o_valid), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
